aes_mixcolumns_iter: RTL
========================

# aes_mixcolumns_iter

Iterative AES MixColumns stage that consumes the 128-bit state produced by the ShiftRows stage. It transforms one 32-bit column per clock over four cycles using a single column datapath. Valid/ready handshakes on both sides let it sit between ShiftRows and AddRoundKey in the round pipeline. A bypass input passes the state through unchanged for the final AES round, which has no MixColumns.

## Interface
- No parameters. Data width is fixed at 128 bits; column count is fixed at 4.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on rising edge of `clk`.
- `in_valid`  in  1  upstream presents `in_state`/`in_bypass`.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `in_state`  in  128  ShiftRows output, column-major; bytes s0..s15 from MSB; column c = bits [127-32c -: 32], row 0 in the column MSB.
- `in_bypass`  in  1  1 = final round: output equals input, no MixColumns.
- `out_valid`  out  1  `out_state` holds a completed result.
- `out_ready`  in  1  downstream accepts the result.
- `out_state`  out  128  result, same byte ordering as `in_state`.

## Operation
- FSM states: IDLE, COMPUTE, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: capture `in_state` into working register W and latch `in_bypass`.
  - Bypass → DONE, with `out_state`=W.
  - Otherwise → COMPUTE, with column counter k=0.
- COMPUTE, one column per cycle:
  - Read column k (a0..a3) from W.
  - Write into column k of `out_state`:
    - b0=2a0^3a1^a2^a3
    - b1=a0^2a1^3a2^a3
    - b2=a0^a1^2a2^3a3
    - b3=3a0^a1^a2^2a3
  - k increments. After k=3 is written, → DONE.
- GF(2^8) arithmetic:
  - xtime(x) = {x[6:0],0} ^ (x[7] ? 8'h1b : 0).
  - 3x = xtime(x)^x.
  - All arithmetic is 8-bit; there is no carry between bytes.
- DONE:
  - `out_valid`=1.
  - `out_state` is held stable until `out_valid`&&`out_ready`, then → IDLE.
- Hard boundary conditions:
  - Inputs are captured at the accept edge. Changes to `in_state`/`in_bypass` afterwards have no effect.
  - `in_ready`=0 throughout COMPUTE and DONE. There is no overlap between transactions; a new transaction is not accepted in the same cycle a result is consumed.
  - k wraps only via the state transition. k is never read outside COMPUTE.
  - `out_ready` high before DONE is ignored. `out_valid` never drops without a handshake.
  - Reset at any point, including mid-COMPUTE or in DONE:
    - state → IDLE, k=0.
    - `out_valid`=0, `in_ready`=1 after the reset edge.
    - `out_state`=128'h0.
    - The in-flight transaction is discarded.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_state`=0, FSM=IDLE, k=0.
- Latency, counted from the accept edge E0:
  - Normal: columns 0..3 are written at E1..E4; `out_valid` is high from E4.
  - Bypass: `out_valid` is high from E1.
- Earliest output handshake is E5 (normal) or E2 (bypass). `in_ready` returns high after the handshake edge.
- Maximum throughput:
  - One state per 6 cycles normal, one per 3 cycles bypass, with `out_ready` tied high.
- All outputs are registered. There is no combinational path from `in_*` to `out_*` or from `out_ready` to `in_ready`.

## Test plan
- FIPS-197 column vectors, no bypass:
  - Stimulus: `in_state`=db135345_f20a225c_01010101_c6c6c6c6, `out_ready`=1.
  - Required: `out_state`=8e4da1bc_9fdc589d_01010101_c6c6c6c6, `out_valid` high exactly 4 edges after accept.
- FIPS-197 round 1:
  - Stimulus: `in_state`=d4bf5d30_e0b452ae_b84111f1_1e2798e5.
  - Required: `out_state`=046681e5_e0cb199a_48f8d37a_2806264c.
- Bypass with backpressure:
  - Stimulus: `in_bypass`=1, `in_state`=0123456789abcdeffedcba9876543210; `out_ready` held 0 for 5 cycles.
  - Required: `out_valid` from E1; `out_state` equals input and stays stable; `in_ready`=0 until the handshake.
- Input corruption after accept:
  - Stimulus: after accepting d4d4d4d5_2d26314c_…, drive `in_state` to random values during COMPUTE.
  - Required: result columns are d5d5d7d6 and 4d7ebdf8, unaffected by the changes.
- Mid-operation reset:
  - Stimulus: assert `rst_n`=0 for one edge at E2 of a transaction.
  - Required: next cycle `out_valid`=0, `out_state`=0, `in_ready`=1. A new transaction then completes correctly.
- Back-to-back stream:
  - Stimulus: 100 random states with random `in_bypass`, `in_valid` always 1, random `out_ready`.
  - Required: results match a reference model, in order, with no drops or duplicates.

Source files
------------

// File: rtl/aes_mixcolumns_iter.sv
// aes_mixcolumns_iter: iterative AES MixColumns, one 32-bit column per clock, with final-round bypass
//   clk, rst_n (sync, active-low)
//   in_valid/in_ready/in_state[127:0]/in_bypass   : ShiftRows side, column-major, s0 in MSB
//   out_valid/out_ready/out_state[127:0]           : AddRoundKey side, same byte order
module aes_mixcolumns_iter (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);
    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
    state_t state, state_nx;
    logic [127:0] w;
    logic [1:0] k;
    logic byp;
    logic [31:0] col, mixed;
    logic [7:0] a0, a1, a2, a3;
    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction
    // column k lives at bits [127-32k -: 32]; ~k gives 3-k
    assign col = w[{~k, 5'b0} +: 32];
    assign {a0, a1, a2, a3} = col;
    assign mixed = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                    a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                    a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                    xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = in_valid ? COMPUTE : IDLE;
            COMPUTE: state_nx = (byp || k == 2'd3) ? DONE : COMPUTE;
            DONE:    state_nx = out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end
    // a bypassed state still spends one cycle in COMPUTE so its result lands one edge after accept
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            w         <= '0;
            k         <= '0;
            byp       <= 1'b0;
            out_state <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && in_valid) begin
                w   <= in_state;
                byp <= in_bypass;
                k   <= '0;
            end
            if (state == COMPUTE) begin
                if (byp) out_state <= w;
                else out_state[{~k, 5'b0} +: 32] <= mixed;
                k <= k + 2'd1;
            end
        end
    end
endmodule
